cpu_lockstep_cmp: RTL and testbench
===================================

// Module: cpu_lockstep_cmp
// PURPOSE
//  Parametrised lockstep bus comparator for the 6502 verification top. Captures CPU bus
//  transactions (addr/data/rw) from NCH CPU instances: channel 0 is the reference model,
//  channels 1..NCH-1 are DUVs. Per-channel FIFOs absorb up to DEPTH transactions of skew.
//  Each DUV stream is compared in order against the reference, with sticky first-error capture.
// PARAMETERS
//  NCH       2   channel count incl. reference (2..8)
//  DEPTH     8   per-channel FIFO depth, power of 2 (2..64)
//  AW        16  transaction address width
//  DW        8   transaction data width
//  MAX_SKEW  64  cycles of unbalanced FIFOs before timeout (>=1)
//  CNT_W     32  statistics counter width
// PORTS
//  clk             in   1          single clock, rising edge
//  b_rst           in   1          synchronous active-low reset
//  en              in   1          1 = capture and compare; 0 = freeze (no push/pop, counters hold)
//  clr_stats       in   1          sync clear of counters and sticky flags; FIFOs untouched
//  ch_mask         in   NCH        1 = DUV channel compared; bit 0 ignored (ref always on)
//  trk_valid       in   NCH        transaction strobe per channel, one txn per asserted cycle
//  trk_addr        in   NCH*AW     per-channel address, channel i at [i*AW +: AW]
//  trk_data        in   NCH*DW     per-channel data
//  trk_rw          in   NCH        1 = read, 0 = write
//  cmp_pulse       out  1          1-cycle pulse per completed compare
//  cmp_count       out  CNT_W      compares done (saturating)
//  err_count       out  CNT_W      compares with >=1 mismatching channel (saturating)
//  mismatch        out  1          sticky: any mismatch seen
//  first_err_ch    out  3          lowest mismatching channel of first failing compare
//  first_err_addr  out  AW         reference address of first failing compare
//  first_err_exp   out  DW         reference data of first failing compare
//  first_err_act   out  DW         DUV data of first_err_ch
//  overflow        out  NCH        sticky per channel: push dropped on full FIFO
//  timeout         out  1          sticky: skew persisted MAX_SKEW cycles
// BEHAVIOUR
//  - Reset (b_rst=0 at clk edge): all FIFOs empty; every output 0; skew counter 0.
//  - Push: en=1 & trk_valid[i] & channel active (i==0 or ch_mask[i]) -> write FIFO i.
//    Full FIFO: accepted only if the same-cycle pop frees a slot, else dropped, overflow[i]<=1.
//  - Compare: when en=1 and FIFO 0 plus every active DUV FIFO is non-empty (registered
//    state), pop heads of all of them in the same cycle. Mismatch on a channel = any of
//    addr/data/rw differing from reference head.
//  - Latency: valid in cycle n -> entry at head in n+1 -> compare registered, cmp_pulse and
//    counters visible in n+2 (aligned channels). Back-to-back: one compare per cycle sustained.
//  - First error: captured on the first failing compare after reset/clr_stats only; later
//    failures bump err_count, capture regs hold.
//  - Skew counter: increments while en=1, no compare this cycle, and some active FIFO
//    non-empty while another is empty; zeroed on any compare or when all active FIFOs are
//    empty. Reaching MAX_SKEW sets timeout; counter saturates.
//  - ch_mask bit deasserted: that FIFO is flushed next edge and excluded from compare; a
//    mask change mid-run takes effect from the following cycle.
//  - clr_stats has priority over same-cycle compare updates; FIFO contents and pops unaffected.
//  - Counters saturate at all-ones; no wrap. FIFO pointers wrap modulo DEPTH, extra bit for full.
//  - Reset mid-operation: discards all in-flight entries, no compare issued that cycle.
// STRUCTURE
//  - Package cpu_lockstep_pkg: trk_t struct {addr, data, rw}, MAX_NCH=8, trk_cmp() function.
//  - Sub-module trk_fifo (DEPTH x trk_t, sync, push/pop/flush, full/empty, count), one per channel.
//  - Top: compare/pop logic, skew counter, stats and first-error capture registers.
// TESTING
//  1. NCH=2, identical 100-txn streams, zero skew -> cmp_count=100, err_count=0, mismatch=0.
//  2. DUV lags 5 cycles, DEPTH=8 -> all 100 match; no overflow, no timeout.
//  3. Txn #7 DUV data 0xA9 vs ref 0xA5 @0x8004 -> mismatch=1, first_err_addr=0x8004,
//     exp=0xA5, act=0xA9, err_count=1; later error at #20 leaves capture unchanged, err_count=2.
//  4. DUV silent, ref pushes 9 txns, DEPTH=8 -> overflow[0]=1 on 9th; timeout after 64 cycles.
//  5. NCH=4, ch_mask=4'b0101, ch1 garbage, ch2 matches ref -> err_count=0; unmask ch3 (matching)
//     -> compares continue without error.
//  6. clr_stats mid-stream after error -> stats 0; b_rst low mid-burst -> FIFOs empty, outputs 0.

Source files
------------

// File: rtl/cpu_lockstep_cmp_pkg.sv
// Shared types for the lockstep comparator: one captured bus transaction and its compare.
package cpu_lockstep_pkg;

  localparam int MAX_NCH = 8;
  localparam int MAX_AW  = 32;
  localparam int MAX_DW  = 32;

  // Fields are stored at maximum width; unused upper bits are always zero.
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
    logic              rw;
  } trk_t;

  // 1 when both transactions agree on address, data and direction.
  function automatic logic trk_cmp(input trk_t a, input trk_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/cpu_lockstep_cmp_fifo.sv
// Synchronous per-channel transaction FIFO; pointers carry an extra wrap bit for full detection.
module trk_fifo
  import cpu_lockstep_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     b_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  trk_t                     din,
  output trk_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  trk_t         mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same edge frees the head slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!b_rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_lockstep_cmp.sv
// Lockstep bus comparator: channel 0 is the reference, active DUV channels are compared in
// order against it once every active FIFO holds a transaction.
module cpu_lockstep_cmp
  import cpu_lockstep_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DEPTH    = 8,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_SKEW = 64,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              b_rst,
  input  logic              en,
  input  logic              clr_stats,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [NCH-1:0]    trk_valid,
  input  logic [NCH*AW-1:0] trk_addr,
  input  logic [NCH*DW-1:0] trk_data,
  input  logic [NCH-1:0]    trk_rw,
  output logic              cmp_pulse,
  output logic [CNT_W-1:0]  cmp_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              mismatch,
  output logic [2:0]        first_err_ch,
  output logic [AW-1:0]     first_err_addr,
  output logic [DW-1:0]     first_err_exp,
  output logic [DW-1:0]     first_err_act,
  output logic [NCH-1:0]    overflow,
  output logic              timeout
);

  localparam int SW = $clog2(MAX_SKEW + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  trk_t                 din   [NCH];
  trk_t                 head  [NCH];
  logic [$clog2(DEPTH):0] fcnt [NCH];
  logic [NCH-1:0]       act, push, pop, full, empty, nonempty, mm;
  logic                 do_cmp, some_ne, some_e;
  logic [SW-1:0]        skew_cnt, skew_nxt;
  logic [2:0]           err_ch;
  logic [DW-1:0]        err_act;

  // Reference channel is always active regardless of its mask bit.
  assign act = ch_mask | NCH'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign din[i]  = '{addr: MAX_AW'(trk_addr[i*AW +: AW]),
                       data: MAX_DW'(trk_data[i*DW +: DW]),
                       rw:   trk_rw[i]};
    assign push[i] = en & trk_valid[i] & act[i];
    assign pop[i]  = do_cmp & act[i];
    assign nonempty[i] = act[i] & (fcnt[i] != '0);

    trk_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .b_rst (b_rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (~act[i]),
      .din   (din[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (fcnt[i])
    );

    if (i == 0) begin : g_ref
      assign mm[i] = 1'b0;
    end else begin : g_duv
      assign mm[i] = act[i] & ~trk_cmp(head[i], head[0]);
    end
  end

  assign do_cmp  = en & (&(~act | ~empty));
  assign some_ne = |nonempty;
  assign some_e  = |(act & empty);

  always_comb begin
    err_ch  = '0;
    err_act = '0;
    for (int i = NCH - 1; i >= 1; i--) begin
      if (mm[i]) begin
        err_ch  = 3'(i);
        err_act = head[i].data[DW-1:0];
      end
    end
  end

  always_comb begin
    skew_nxt = skew_cnt;
    if (do_cmp || !some_ne)
      skew_nxt = '0;
    else if (en && some_e && skew_cnt != SW'(MAX_SKEW))
      skew_nxt = skew_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!b_rst) begin
      cmp_pulse      <= 1'b0;
      cmp_count      <= '0;
      err_count      <= '0;
      mismatch       <= 1'b0;
      first_err_ch   <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
      overflow       <= '0;
      timeout        <= 1'b0;
      skew_cnt       <= '0;
    end else begin
      cmp_pulse <= do_cmp;
      if (clr_stats) begin
        cmp_count      <= '0;
        err_count      <= '0;
        mismatch       <= 1'b0;
        first_err_ch   <= '0;
        first_err_addr <= '0;
        first_err_exp  <= '0;
        first_err_act  <= '0;
        overflow       <= '0;
        timeout        <= 1'b0;
        skew_cnt       <= '0;
      end else begin
        skew_cnt <= skew_nxt;
        if (skew_nxt == SW'(MAX_SKEW)) timeout <= 1'b1;
        overflow <= overflow | (push & full & ~pop);
        if (do_cmp) begin
          cmp_count <= sat_inc(cmp_count);
          if (|mm) begin
            err_count <= sat_inc(err_count);
            // Capture registers describe only the first failure since reset or clear.
            if (!mismatch) begin
              mismatch       <= 1'b1;
              first_err_ch   <= err_ch;
              first_err_addr <= head[0].addr[AW-1:0];
              first_err_exp  <= head[0].data[DW-1:0];
              first_err_act  <= err_act;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// Scoreboard bench for cpu_lockstep_cmp: expectations queued at stimulus, checked on cmp_pulse.
module tb_cpu_lockstep_cmp;

  localparam int NCH = 4, DEPTH = 8, AW = 16, DW = 8, MAX_SKEW = 64, CNT_W = 32;

  logic              clk = 1'b0;
  logic              b_rst, en, clr_stats;
  logic [NCH-1:0]    ch_mask, trk_valid, trk_rw;
  logic [NCH*AW-1:0] trk_addr;
  logic [NCH*DW-1:0] trk_data;
  logic              cmp_pulse, mismatch, timeout;
  logic [CNT_W-1:0]  cmp_count, err_count;
  logic [2:0]        first_err_ch;
  logic [AW-1:0]     first_err_addr;
  logic [DW-1:0]     first_err_exp, first_err_act;
  logic [NCH-1:0]    overflow;

  typedef struct { int cmp; int err; } exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  int m_cmp = 0, m_err = 0;

  cpu_lockstep_cmp #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW), .MAX_SKEW(MAX_SKEW), .CNT_W(CNT_W)) dut (
    .clk(clk), .b_rst(b_rst), .en(en), .clr_stats(clr_stats), .ch_mask(ch_mask),
    .trk_valid(trk_valid), .trk_addr(trk_addr), .trk_data(trk_data), .trk_rw(trk_rw),
    .cmp_pulse(cmp_pulse), .cmp_count(cmp_count), .err_count(err_count), .mismatch(mismatch),
    .first_err_ch(first_err_ch), .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every compare pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (b_rst === 1'b1 && cmp_pulse === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_cmp_pulse", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("sb_cmp_count", cmp_count, e.cmp);
        chk("sb_err_count", err_count, e.err);
      end
    end
  end

  function automatic logic [AW-1:0] a_of(input int base, input int k);
    return AW'(base + k);
  endfunction

  function automatic logic [DW-1:0] d_of(input int k);
    return DW'(8'h9E + k);
  endfunction

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    trk_valid[ch]          = 1'b1;
    trk_addr[ch*AW +: AW]  = a;
    trk_data[ch*DW +: DW]  = d;
    trk_rw[ch]             = rw;
  endtask

  // ch0/ch2/ch3 carry the reference stream; ch1 lags by 'lag' cycles and may be corrupted.
  task automatic run_stream(input int n, input int base, input int lag,
                            input int bad_a, input int bad_b, input bit garbage);
    int k;
    logic bad;
    for (int c = 0; c < n + lag; c++) begin
      @(negedge clk);
      trk_valid = '0;
      if (c < n) begin
        set_ch(0, a_of(base, c), d_of(c), 1'(c & 1));
        set_ch(2, a_of(base, c), d_of(c), 1'(c & 1));
        set_ch(3, a_of(base, c), d_of(c), 1'(c & 1));
        m_cmp++;
        if (ch_mask[1] && (garbage || c == bad_a || c == bad_b)) m_err++;
        sbq.push_back('{m_cmp, m_err});
      end
      if (c >= lag && c - lag < n) begin
        k   = c - lag;
        bad = garbage || k == bad_a || k == bad_b;
        set_ch(1, a_of(base, k) ^ (garbage ? 16'h5555 : 16'h0000),
               d_of(k) ^ (bad ? 8'h0C : 8'h00), 1'(k & 1));
      end
    end
    @(negedge clk);
    trk_valid = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmp_count"}, cmp_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_first_err"}, {first_err_ch, first_err_addr, first_err_exp, first_err_act}, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cmp_pulse"}, cmp_pulse, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    b_rst = 1'b0; en = 1'b0; clr_stats = 1'b0; ch_mask = 4'b0011;
    trk_valid = '0; trk_addr = '0; trk_data = '0; trk_rw = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    b_rst = 1'b1; en = 1'b1;

    // Identical streams, no skew
    run_stream(100, 'h0200, 0, -1, -1, 1'b0);
    drain();
    chk("t1_cmp_count", cmp_count, 100);
    chk("t1_err_count", err_count, 0);
    chk("t1_mismatch", mismatch, 0);

    // DUV lags five cycles
    run_stream(100, 'h0300, 5, -1, -1, 1'b0);
    drain();
    chk("t2_cmp_count", cmp_count, 200);
    chk("t2_overflow", overflow, 0);
    chk("t2_timeout", timeout, 0);

    // Errors at txn 7 and 20
    run_stream(30, 'h7FFD, 0, 7, 20, 1'b0);
    drain();
    chk("t3_mismatch", mismatch, 1);
    chk("t3_first_err_ch", first_err_ch, 1);
    chk("t3_first_err_addr", first_err_addr, 16'h8004);
    chk("t3_first_err_exp", first_err_exp, 8'hA5);
    chk("t3_first_err_act", first_err_act, 8'hA9);
    chk("t3_err_count", err_count, 2);

    // Clear statistics after the error
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    m_cmp = 0; m_err = 0;
    chk_all_zero("clr");

    // Four channels, ch1 masked with garbage, then ch3 unmasked
    ch_mask = 4'b0101;
    run_stream(20, 'h1000, 0, -1, -1, 1'b1);
    drain();
    chk("t5a_cmp_count", cmp_count, 20);
    chk("t5a_err_count", err_count, 0);
    ch_mask = 4'b1101;
    run_stream(20, 'h1100, 0, -1, -1, 1'b1);
    drain();
    chk("t5b_cmp_count", cmp_count, 40);
    chk("t5b_err_count", err_count, 0);
    chk("t5b_mismatch", mismatch, 0);

    // Silent DUV: overflow on the ninth reference push, then skew timeout
    ch_mask = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      trk_valid = '0;
      set_ch(0, a_of('h4000, k), d_of(k), 1'b0);
    end
    @(negedge clk); trk_valid = '0;
    chk("t4_overflow", overflow, 4'b0001);
    chk("t4_timeout_early", timeout, 0);
    repeat (70) @(negedge clk);
    chk("t4_timeout", timeout, 1);
    chk("t4_cmp_count", cmp_count, 40);

    // Reset in the middle of a burst discards stale reference entries
    set_ch(0, a_of('h5000, 0), d_of(0), 1'b0);
    b_rst = 1'b0;
    @(negedge clk);
    set_ch(0, a_of('h5000, 1), d_of(1), 1'b0);
    @(negedge clk);
    trk_valid = '0; b_rst = 1'b1;
    sbq.delete(); m_cmp = 0; m_err = 0;
    chk_all_zero("rst_mid");
    run_stream(10, 'h2000, 0, -1, -1, 1'b0);
    drain();
    chk("t6_cmp_count", cmp_count, 10);
    chk("t6_err_count", err_count, 0);
    chk("t6_mismatch", mismatch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
